// File: rtl/sr_pkg.sv
// Shared definitions for the synchronous SR latch.
//   sr_state_t     : latch state encoding (ST_RST, ST_SET, ST_FORBID)
//   CNT_W_DEFAULT  : default width of the forbidden-event counter
//   q_of / qbar_of : output decode of a state
package sr_pkg;

    typedef enum logic [1:0] {
        ST_RST    = 2'b00,
        ST_SET    = 2'b01,
        ST_FORBID = 2'b10
    } sr_state_t;

    localparam int CNT_W_DEFAULT = 8;

    // Q is high in SET and FORBID.
    function automatic logic q_of(input sr_state_t s);
        return (s != ST_RST);
    endfunction

    // Qbar is high in RST and FORBID, so Q and Qbar are never both low.
    function automatic logic qbar_of(input sr_state_t s);
        return (s != ST_SET);
    endfunction

endpackage

// File: rtl/sr_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset, forces cnt to 0
//   clr : synchronous clear; if inc is also high the count restarts at 1
//   inc : count one event
//   cnt : current count, sticks at 2^W-1
module sr_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] r_cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            // An event on the clearing edge is counted, not lost.
            r_cnt <= inc ? CNT_ONE : '0;
        end else if (inc && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/sr_sync_latch.sv
// Clocked model of an active-low SR latch, including the forbidden S=R=0
// condition and its race resolution when both inputs release together.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   S, R       : active-low set / reset inputs, sampled on each edge
//   clr_cnt    : synchronous clear of forbid_cnt
//   Q, Qbar    : registered outputs (both high in FORBID)
//   forbid     : high while in FORBID
//   race       : one-cycle pulse when FORBID resolves through S=R=1
//   forbid_cnt : saturating count of FORBID entries
module sr_sync_latch
    import sr_pkg::*;
#(
    parameter logic RACE_POLICY = 1'b0,
    parameter int   CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S,
    input  logic             R,
    input  logic             clr_cnt,
    output logic             Q,
    output logic             Qbar,
    output logic             forbid,
    output logic             race,
    output logic [CNT_W-1:0] forbid_cnt
);

    sr_state_t r_state;
    sr_state_t w_next;
    logic      w_race;
    logic      w_enter_forbid;

    logic r_q;
    logic r_qbar;
    logic r_forbid;
    logic r_race;

    // Next-state logic. Inputs are active low.
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next = r_state;
        w_race = 1'b0;
        unique case ({S, R})
            2'b01:   w_next = ST_SET;
            2'b10:   w_next = ST_RST;
            2'b00:   w_next = ST_FORBID;
            default: begin
                // Both released: SET/RST hold; FORBID races to a fixed winner.
                if (r_state == ST_FORBID) begin
                    w_next = RACE_POLICY ? ST_SET : ST_RST;
                    w_race = 1'b1;
                end
            end
        endcase
    end

    assign w_enter_forbid = (w_next == ST_FORBID) && (r_state != ST_FORBID);

    // Outputs are registered from the next state so they sit directly on flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RST;
            r_q      <= 1'b0;
            r_qbar   <= 1'b1;
            r_forbid <= 1'b0;
            r_race   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_q      <= q_of(w_next);
            r_qbar   <= qbar_of(w_next);
            r_forbid <= (w_next == ST_FORBID);
            r_race   <= w_race;
        end
    end

    // Reset has priority inside the counter, so a reset edge in FORBID
    // neither counts nor pulses race.
    sr_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (w_enter_forbid),
        .cnt (forbid_cnt)
    );

    assign Q      = r_q;
    assign Qbar   = r_qbar;
    assign forbid = r_forbid;
    assign race   = r_race;

endmodule

// File: tb/tb_sr_sync_latch.sv
// Self-checking bench for sr_sync_latch. Three instances share one stimulus:
//   dut0 : RACE_POLICY=0, CNT_W=8
//   dut1 : RACE_POLICY=1, CNT_W=8
//   dut2 : RACE_POLICY=0, CNT_W=2
module tb_sr_sync_latch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_n = 1'b1;
    logic r_n = 1'b1;
    logic clr = 1'b0;

    logic       q0, qb0, f0, rc0;
    logic [7:0] c0;
    logic       q1, qb1, f1, rc1;
    logic [7:0] c1;
    logic       q2, qb2, f2, rc2;
    logic [1:0] c2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sr_sync_latch #(.RACE_POLICY(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .S(s_n), .R(r_n), .clr_cnt(clr),
        .Q(q0), .Qbar(qb0), .forbid(f0), .race(rc0), .forbid_cnt(c0)
    );
    sr_sync_latch #(.RACE_POLICY(1'b1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .S(s_n), .R(r_n), .clr_cnt(clr),
        .Q(q1), .Qbar(qb1), .forbid(f1), .race(rc1), .forbid_cnt(c1)
    );
    sr_sync_latch #(.RACE_POLICY(1'b0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .S(s_n), .R(r_n), .clr_cnt(clr),
        .Q(q2), .Qbar(qb2), .forbid(f2), .race(rc2), .forbid_cnt(c2)
    );

    typedef struct {
        logic       rst;
        logic       s;
        logic       r;
        logic       clr;
        logic       eq;     // dut0 expectations
        logic       eqb;
        logic       ef;
        logic       er;
        logic [7:0] ec;
        logic       eq1;    // dut1 Q (differs only after a race)
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rs, input logic s, input logic r,
                                input logic cl, input logic eq, input logic eqb,
                                input logic ef, input logic er,
                                input logic [7:0] ec, input logic eq1);
        vec_t v;
        v.rst = rs; v.s = s; v.r = r; v.clr = cl;
        v.eq = eq; v.eqb = eqb; v.ef = ef; v.er = er; v.ec = ec; v.eq1 = eq1;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic rs, input logic s, input logic r,
                        input logic cl);
        @(negedge clk);
        rst = rs; s_n = s; r_n = r; clr = cl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_c2;
        logic       exp_qb1;

        //   rst s r clr | Q Qb F race cnt | Q1
        add(1, 1, 1, 0,   0, 1, 0, 0, 0,    0);  // reset
        add(0, 0, 1, 0,   1, 0, 0, 0, 0,    1);  // set
        add(0, 1, 1, 0,   1, 0, 0, 0, 0,    1);  // hold set
        add(0, 1, 0, 0,   0, 1, 0, 0, 0,    0);  // reset
        add(0, 1, 1, 0,   0, 1, 0, 0, 0,    0);  // hold reset
        add(0, 0, 1, 0,   1, 0, 0, 0, 0,    1);  // set
        add(0, 0, 0, 0,   1, 1, 1, 0, 1,    1);  // enter FORBID
        add(0, 1, 1, 0,   0, 1, 0, 1, 1,    1);  // race resolution
        add(0, 1, 1, 0,   0, 1, 0, 0, 1,    1);  // race pulse ended
        add(0, 0, 0, 0,   1, 1, 1, 0, 2,    1);  // FORBID held 5 cycles
        add(0, 0, 0, 0,   1, 1, 1, 0, 2,    1);
        add(0, 0, 0, 0,   1, 1, 1, 0, 2,    1);
        add(0, 0, 0, 0,   1, 1, 1, 0, 2,    1);
        add(0, 0, 0, 0,   1, 1, 1, 0, 2,    1);
        add(0, 0, 1, 0,   1, 0, 0, 0, 2,    1);  // leave via set, no race
        add(0, 0, 0, 0,   1, 1, 1, 0, 3,    1);  // enter FORBID
        add(1, 0, 0, 0,   0, 1, 0, 0, 0,    0);  // reset while in FORBID
        add(0, 1, 1, 0,   0, 1, 0, 0, 0,    0);  // first edge after reset
        add(0, 0, 0, 1,   1, 1, 1, 0, 1,    1);  // clear with FORBID entry
        add(0, 1, 0, 1,   0, 1, 0, 0, 0,    0);  // plain clear, leave via reset
        add(0, 0, 0, 0,   1, 1, 1, 0, 1,    1);
        add(0, 1, 0, 0,   0, 1, 0, 0, 1,    0);  // leave via reset, no race

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].s, vecs[i].r, vecs[i].clr);
            check($sformatf("v%0d q0", i),      q0,  vecs[i].eq);
            check($sformatf("v%0d qbar0", i),   qb0, vecs[i].eqb);
            check($sformatf("v%0d forbid0", i), f0,  vecs[i].ef);
            check($sformatf("v%0d race0", i),   rc0, vecs[i].er);
            check($sformatf("v%0d cnt0", i),    c0,  vecs[i].ec);
            exp_qb1 = vecs[i].ef ? 1'b1 : ~vecs[i].eq1;
            check($sformatf("v%0d q1", i),      q1,  vecs[i].eq1);
            check($sformatf("v%0d qbar1", i),   qb1, exp_qb1);
            check($sformatf("v%0d race1", i),   rc1, vecs[i].er);
            exp_c2 = (vecs[i].ec > 8'd3) ? 8'd3 : vecs[i].ec;
            check($sformatf("v%0d cnt2", i),    {6'd0, c2}, exp_c2);
            check($sformatf("v%0d q_or_qbar", i), q0 | qb0, 1'b1);
        end

        // Six separate FORBID entries: 8-bit count climbs, 2-bit count sticks at 3.
        step(1, 1, 1, 0);
        check("sat rst cnt2", {6'd0, c2}, 8'd0);
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 0, 0);
            check($sformatf("sat entry%0d cnt0", k), c0, 8'(k));
            check($sformatf("sat entry%0d cnt2", k), {6'd0, c2},
                  (k > 3) ? 8'd3 : 8'(k));
            step(0, 1, 0, 0);
            check($sformatf("sat exit%0d race0", k), rc0, 1'b0);
        end
        step(0, 0, 0, 1);
        check("sat clr+entry cnt0", c0, 8'd1);
        check("sat clr+entry cnt2", {6'd0, c2}, 8'd1);
        check("sat clr+entry forbid2", f2, 1'b1);

        // Race resolution from FORBID with RACE_POLICY=1: pulse lasts one cycle.
        step(0, 1, 1, 0);
        check("race1 pulse", rc1, 1'b1);
        check("race1 q", q1, 1'b1);
        check("race1 qbar", qb1, 1'b0);
        check("race1 forbid", f1, 1'b0);
        step(0, 1, 1, 0);
        check("race1 pulse end", rc1, 1'b0);
        check("race1 q held", q1, 1'b1);
        check("race1 cnt", c1, 8'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_sync_latch.md
SR_SYNC_LATCH -- requirements
Module: sr_sync_latch

Interface
REQ-001 The block SHALL be parameterised as follows.
  - RACE_POLICY, 1'b0, Q value taken when leaving FORBID directly to hold (S=R=1).
  - CNT_W, 8, width of the forbidden-event counter.
REQ-002 The block SHALL have the following ports.
  - clk  input  1  sole clock; all state changes on the rising edge.
  - rst  input  1  synchronous, active-high reset.
  - S  input  1  active-low set.
  - R  input  1  active-low reset.
  - clr_cnt  input  1  synchronous clear of forbid_cnt.
  - Q  output  1  registered latch output.
  - Qbar  output  1  registered complementary output; equals ~Q except in FORBID.
  - forbid  output  1  high while state is FORBID.
  - race  output  1  one-cycle pulse on a FORBID->hold race resolution.
  - forbid_cnt  output  CNT_W  saturating count of FORBID entries.
REQ-003 The block SHALL use one clock (clk), and its reset SHALL be synchronous and active-high (rst).

Function
REQ-004 The block SHALL sample S and R on each rising clk edge, and SHALL present the resulting outputs after that same edge (one-cycle latency, registered outputs, no combinational input-to-output path).
REQ-005 The state machine SHALL have exactly the states ST_RST (Q=0, Qbar=1), ST_SET (Q=1, Qbar=0) and ST_FORBID (Q=1, Qbar=1).
REQ-006 S=0 and R=1 SHALL move the block to ST_SET from any state.
REQ-007 S=1 and R=0 SHALL move the block to ST_RST from any state.
REQ-008 S=0 and R=0 SHALL move the block to ST_FORBID from any state.
REQ-009 S=1 and R=1 SHALL hold ST_SET or ST_RST unchanged.
REQ-010 S=1 and R=1 in ST_FORBID SHALL move the block to ST_SET if RACE_POLICY=1, otherwise to ST_RST, and SHALL assert race for exactly that one cycle.
REQ-011 Leaving ST_FORBID via S=0,R=1 or S=1,R=0 SHALL NOT assert race.
REQ-012 forbid SHALL be high exactly when the state is ST_FORBID.
REQ-013 forbid_cnt SHALL increment by 1 on each transition into ST_FORBID from another state, and SHALL NOT increment while ST_FORBID is held.
REQ-014 forbid_cnt SHALL saturate at 2^CNT_W-1 with no wrap-around.
REQ-015 clr_cnt=1 SHALL set forbid_cnt to 0 on the next edge; if that same edge is also a ST_FORBID entry, forbid_cnt SHALL become 1.
REQ-016 Q and Qbar SHALL never both be 0.

Reset
REQ-017 When rst=1 on an edge, the block SHALL set state=ST_RST, Q=0, Qbar=1, forbid=0, race=0 and forbid_cnt=0, regardless of S, R and clr_cnt.
REQ-018 Reset asserted while in ST_FORBID SHALL NOT pulse race and SHALL NOT count an event.
REQ-019 After rst deasserts, the first edge SHALL process S and R normally.

Structure
REQ-020 State encodings (ST_RST, ST_SET, ST_FORBID) and the default CNT_W SHALL live in shared package sr_pkg.
REQ-021 The saturating counter with clear SHALL be the sub-module sr_sat_cnt (parameter W; ports clk, rst, clr, inc, cnt).
REQ-022 The state register and output decode SHALL stay in sr_sync_latch.

Verification
REQ-023 The bench SHALL cover these directed scenarios.
  - Reset, then the sequence (S,R) = 01, 11, 10, 11 with one edge each -> (Q,Qbar) = 10, 10, 01, 01; race=0; forbid_cnt=0.
  - From ST_SET, apply 00 then 11 with RACE_POLICY=0 -> (Q,Qbar) = 11 with forbid=1, then 01 with a one-cycle race pulse; forbid_cnt=1.
  - Same as the previous scenario with RACE_POLICY=1 -> ends at Q=1, Qbar=0 with race pulsed once.
  - Apply 00 for 5 cycles, then 01 -> forbid_cnt=1, race=0, Q=1, Qbar=0.
  - CNT_W=2, six separate FORBID entries -> forbid_cnt sequence 1, 2, 3, 3, 3, 3; then clr_cnt together with a FORBID entry -> forbid_cnt=1.
  - rst asserted while in ST_FORBID with S=R=0 -> Q=0, Qbar=1, forbid=0, race=0, forbid_cnt=0 on that edge.
